alu_md: RTL

ALU_MD -- requirements
Module: alu_md

---
 rtl/alu_md_if.sv | 27 ++
 rtl/alu_md.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_md_if.sv
// Request/response bundle for the alu_md arithmetic unit.
// master = requester side, slave = alu_md.
interface alu_md_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [4:0]      opcode;
  logic [XLEN-1:0] input1;
  logic [XLEN-1:0] input2;
  logic            flush;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] out;

  modport master (
    output req_valid, opcode, input1, input2,
    output flush, resp_ready,
    input  req_ready, resp_valid, out
  );

  modport slave (
    input  req_valid, opcode, input1, input2,
    input  flush, resp_ready,
    output req_ready, resp_valid, out
  );
endinterface

// File: rtl/alu_md.sv
// Single-cycle ALU plus iterative shift-add multiplier and
// restoring divider behind a valid/ready request/response port.
module alu_md #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input logic     clk,
  input logic     reset,
  alu_md_if.slave io
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]    a_q, a_d;
  logic [XLEN-1:0]    hi_q, hi_d;
  logic [XLEN-1:0]    lo_q, lo_d;
  logic [XLEN-1:0]    out_q, out_d;
  logic [1:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;

  logic [XLEN-1:0]    in1, in2, alu_res;
  logic [SHAMT_W-1:0] shamt;
  logic               lt_s, lt_u;

  assign in1   = io.input1;
  assign in2   = io.input2;
  assign shamt = in2[SHAMT_W-1:0];
  assign lt_s  = $signed(in1) < $signed(in2);
  assign lt_u  = in1 < in2;

  always_comb begin
    alu_res = '0;
    case (io.opcode)
      5'd0:    alu_res = in1 + in2;
      5'd1:    alu_res = in1 << shamt;
      5'd2:    alu_res = in1 ^ in2;
      5'd3:    alu_res = in1 | in2;
      5'd4:    alu_res = in1 & in2;
      5'd5:    alu_res = in1 >> shamt;
      5'd6:    alu_res = {{(XLEN-1){1'b0}}, in1 == in2};
      5'd7:    alu_res = {{(XLEN-1){1'b0}}, in1 != in2};
      5'd8:    alu_res = in1 - in2;
      5'd9:    alu_res = $unsigned($signed(in1) >>> shamt);
      5'd10:   alu_res = {{(XLEN-1){1'b0}}, lt_s};
      5'd11:   alu_res = {{(XLEN-1){1'b0}}, !lt_s};
      5'd12:   alu_res = {{(XLEN-1){1'b0}}, lt_u};
      5'd13:   alu_res = {{(XLEN-1){1'b0}}, !lt_u};
      default: alu_res = '0;
    endcase
  end

  // Operand classification, signs and magnitudes at acceptance
  logic            acc, is_md, is_mul, is_div, sgn;
  logic            s1, s2, neg1, neg2, div0, ovf;
  logic            div0_go, ovf_go, div_go, alu_go;
  logic [XLEN-1:0] m1, m2;

  assign acc    = (state_q == IDLE) && io.req_valid && !io.flush;
  assign is_md  = io.opcode[4] && !io.opcode[3];
  assign is_mul = is_md && !io.opcode[2];
  assign is_div = is_md && io.opcode[2];
  assign sgn    = !io.opcode[0];
  assign s1     = is_mul ? (io.opcode[1] ^ io.opcode[0])
                         : (is_div && sgn);
  assign s2     = is_mul ? (io.opcode[1:0] == 2'b01)
                         : (is_div && sgn);
  assign neg1   = s1 && in1[XLEN-1];
  assign neg2   = s2 && in2[XLEN-1];
  assign m1     = neg1 ? -in1 : in1;
  assign m2     = neg2 ? -in2 : in2;
  assign div0   = (in2 == '0);
  assign ovf    = sgn && (in1 == {1'b1, {(XLEN-1){1'b0}}})
                  && (&in2);
  assign div0_go = is_div && div0;
  assign ovf_go  = is_div && ovf;
  assign div_go  = is_div && !div0 && !ovf;
  assign alu_go  = !is_md;

  // One shift-add step: {hi,lo} holds the partial product
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi, mul_lo;
  logic [2*XLEN-1:0] prod_u, prod;

  assign mul_sum = {1'b0, hi_q}
                 + (lo_q[0] ? {1'b0, a_q} : '0);
  assign mul_hi  = mul_sum[XLEN:1];
  assign mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
  assign prod_u  = {mul_hi, mul_lo};
  assign prod    = neg_q ? -prod_u : prod_u;

  // One restoring step: hi = partial remainder, lo = dividend/quotient
  logic [XLEN:0]   div_r;
  logic            div_ge;
  logic [XLEN-1:0] div_rem, div_quo, rem_s, quo_s;

  assign div_r   = {hi_q, lo_q[XLEN-1]};
  assign div_ge  = div_r >= {1'b0, a_q};
  assign div_rem = div_ge ? XLEN'(div_r - {1'b0, a_q})
                          : div_r[XLEN-1:0];
  assign div_quo = {lo_q[XLEN-2:0], div_ge};
  assign quo_s   = neg_q ? -div_quo : div_quo;
  assign rem_s   = rneg_q ? -div_rem : div_rem;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    out_d   = out_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    unique case (state_q)
      IDLE: if (acc) begin
        op_d   = io.opcode[1:0];
        cnt_d  = '0;
        hi_d   = '0;
        neg_d  = neg1 ^ neg2;
        rneg_d = neg1;
        unique case (1'b1)
          is_mul: begin
            state_d = MUL;
            a_d     = m1;
            lo_d    = m2;
          end
          div0_go: begin
            state_d = DONE;
            out_d   = io.opcode[1] ? in1 : '1;
          end
          ovf_go: begin
            state_d = DONE;
            out_d   = io.opcode[1] ? '0 : in1;
          end
          div_go: begin
            state_d = DIV;
            a_d     = m2;
            lo_d    = m1;
          end
          alu_go: begin
            state_d = DONE;
            out_d   = alu_res;
          end
          default: state_d = IDLE;
        endcase
      end
      MUL: begin
        hi_d  = mul_hi;
        lo_d  = mul_lo;
        cnt_d = cnt_q + SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(XLEN-1)) begin
          state_d = DONE;
          out_d   = (op_q == 2'b00) ? prod[XLEN-1:0]
                                    : prod[2*XLEN-1:XLEN];
        end
        if (io.flush) state_d = IDLE;
      end
      DIV: begin
        hi_d  = div_rem;
        lo_d  = div_quo;
        cnt_d = cnt_q + SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(XLEN-1)) begin
          state_d = DONE;
          out_d   = op_q[1] ? rem_s : quo_s;
        end
        if (io.flush) state_d = IDLE;
      end
      DONE: begin
        if (io.flush || io.resp_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      out_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      out_q   <= out_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign io.req_ready  = (state_q == IDLE);
  assign io.resp_valid = (state_q == DONE);
  assign io.out        = out_q;
endmodule
